// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage feeding the ALU.
// Captures decoded operands, ALU control and writeback tag, resolves RAW
// hazards by forwarding from EX/MEM and MEM/WB, and presents registered
// a/b/aluc to the ALU. Supports stall (hold) and flush (bubble).
// Optional feature macro: EX_FORWARD_EN (defined = operand forwarding on;
// undefined = operands captured straight from decode, fwd outputs tied 0).
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          id_valid,
  input  logic [DW-1:0] id_qa,
  input  logic [DW-1:0] id_qb,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_bimm,
  input  logic          id_shift,
  input  logic [4:0]    id_sa,
  input  logic [3:0]    id_aluc,
  input  logic          id_wreg,
  input  logic [RW-1:0] id_rd,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_wreg,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_r,
  input  logic          wb_wreg,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_d,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_aluc,
  output logic          ex_wreg,
  output logic [RW-1:0] ex_rd,
  output logic [1:0]    ex_fwd_a,
  output logic [1:0]    ex_fwd_b
);

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [3:0]    aluc_q, aluc_d;
  logic          wreg_q, wreg_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [1:0]    fwdA_q, fwdA_d;
  logic [1:0]    fwdB_q, fwdB_d;

  logic [DW-1:0] opA, opB;
  logic [1:0]    selA, selB;
  logic [DW-1:0] shamtExt;

  assign shamtExt = {{(DW-5){1'b0}}, id_sa};

`ifdef EX_FORWARD_EN
  logic memHitA, wbHitA, memHitB, wbHitB;

  // Register 0 is hardwired, so a pending write to it never forwards.
  assign memHitA = mem_wreg && (mem_rd != '0) && (mem_rd == id_rs);
  assign wbHitA  = wb_wreg  && (wb_rd  != '0) && (wb_rd  == id_rs);
  assign memHitB = mem_wreg && (mem_rd != '0) && (mem_rd == id_rt);
  assign wbHitB  = wb_wreg  && (wb_rd  != '0) && (wb_rd  == id_rt);

  // Operand selection: shamt overrides a, immediates bypass b, and the
  // younger EX/MEM result takes priority over MEM/WB.
  always_comb begin
    opA  = id_qa;
    selA = FWD_NONE;
    opB  = id_qb;
    selB = FWD_NONE;
    if (id_shift) begin
      opA = shamtExt;
    end else if (memHitA) begin
      opA  = mem_r;
      selA = FWD_MEM;
    end else if (wbHitA) begin
      opA  = wb_d;
      selA = FWD_WB;
    end
    if (!id_bimm) begin
      if (memHitB) begin
        opB  = mem_r;
        selB = FWD_MEM;
      end else if (wbHitB) begin
        opB  = wb_d;
        selB = FWD_WB;
      end
    end
  end
`else
  logic unused_fwd;

  // Without forwarding the later-stage results and source indices are not
  // consulted; hazard control is expected to stall instead.
  assign unused_fwd = ^{mem_wreg, mem_rd, mem_r, wb_wreg, wb_rd, wb_d,
                        id_rs, id_rt, id_bimm, FWD_MEM, FWD_WB};

  // Operands come straight from decode, with shamt replacing a on shifts.
  always_comb begin
    opA  = id_shift ? shamtExt : id_qa;
    opB  = id_qb;
    selA = FWD_NONE;
    selB = FWD_NONE;
  end
`endif

  // Next-state: flush beats stall, stall holds, otherwise load (a decode
  // bubble loads as an all-zero bubble so it can never write).
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    aluc_d  = aluc_q;
    wreg_d  = wreg_q;
    rd_d    = rd_q;
    fwdA_d  = fwdA_q;
    fwdB_d  = fwdB_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      aluc_d  = '0;
      wreg_d  = 1'b0;
      rd_d    = '0;
      fwdA_d  = FWD_NONE;
      fwdB_d  = FWD_NONE;
    end else if (!stall) begin
      valid_d = 1'b1;
      a_d     = opA;
      b_d     = opB;
      aluc_d  = id_aluc;
      wreg_d  = id_wreg;
      rd_d    = id_rd;
      fwdA_d  = selA;
      fwdB_d  = selB;
    end
  end

  // Stage registers; asynchronous reset presents a bubble to the ALU.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      wreg_q  <= 1'b0;
      rd_q    <= '0;
      fwdA_q  <= FWD_NONE;
      fwdB_q  <= FWD_NONE;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      wreg_q  <= wreg_d;
      rd_q    <= rd_d;
      fwdA_q  <= fwdA_d;
      fwdB_q  <= fwdB_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_aluc  = aluc_q;
  assign ex_wreg  = wreg_q;
  assign ex_rd    = rd_q;
  assign ex_fwd_a = fwdA_q;
  assign ex_fwd_b = fwdB_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage. Expected values are hand-computed per
// vector; forwarded values are chosen according to EX_FORWARD_EN.
module tb_id_ex_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_valid;
  logic [31:0] id_qa, id_qb;
  logic [4:0]  id_rs, id_rt;
  logic        id_bimm, id_shift;
  logic [4:0]  id_sa;
  logic [3:0]  id_aluc;
  logic        id_wreg;
  logic [4:0]  id_rd;
  logic        stall, flush;
  logic        mem_wreg;
  logic [4:0]  mem_rd;
  logic [31:0] mem_r;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_d;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_aluc;
  logic        ex_wreg;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_fwd_a, ex_fwd_b;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        wreg;
    logic [4:0]  rd;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_qa(id_qa), .id_qb(id_qb),
    .id_rs(id_rs), .id_rt(id_rt), .id_bimm(id_bimm), .id_shift(id_shift),
    .id_sa(id_sa), .id_aluc(id_aluc), .id_wreg(id_wreg), .id_rd(id_rd),
    .stall(stall), .flush(flush), .mem_wreg(mem_wreg), .mem_rd(mem_rd),
    .mem_r(mem_r), .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_d(wb_d),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
    .ex_wreg(ex_wreg), .ex_rd(ex_rd), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  always #5 clk = ~clk;

  // Single comparison with failure report
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input string tag, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] aluc,
                                 input logic wreg, input logic [4:0] rd,
                                 input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.tag = tag; e.valid = v; e.a = a; e.b = b; e.aluc = aluc;
    e.wreg = wreg; e.rd = rd; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  task automatic setInstr(input logic v, input logic [31:0] qa, input logic [31:0] qb,
                          input logic [4:0] rs, input logic [4:0] rt, input logic bimm,
                          input logic shift, input logic [4:0] sa, input logic [3:0] aluc,
                          input logic wreg, input logic [4:0] rd);
    id_valid = v; id_qa = qa; id_qb = qb; id_rs = rs; id_rt = rt; id_bimm = bimm;
    id_shift = shift; id_sa = sa; id_aluc = aluc; id_wreg = wreg; id_rd = rd;
  endtask

  task automatic setFwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mr,
                        input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
    mem_wreg = mw; mem_rd = mrd; mem_r = mr; wb_wreg = ww; wb_rd = wrd; wb_d = wd;
  endtask

  // Called at a falling edge: queue the expectation for the next rising edge
  task automatic applyStimulus(input logic st, input logic fl, input exp_t e);
    stall = st;
    flush = fl;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
    checkOutput({tag, ".a"}, ex_a, 32'd0);
    checkOutput({tag, ".b"}, ex_b, 32'd0);
    checkOutput({tag, ".aluc"}, {28'd0, ex_aluc}, 32'd0);
    checkOutput({tag, ".wreg"}, {31'd0, ex_wreg}, 32'd0);
    checkOutput({tag, ".rd"}, {27'd0, ex_rd}, 32'd0);
    checkOutput({tag, ".fwd"}, {28'd0, ex_fwd_a, ex_fwd_b}, 32'd0);
  endtask

  // Monitor: after every rising edge, pop one expectation if any is pending
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
        checkOutput({e.tag, ".a"}, ex_a, e.a);
        checkOutput({e.tag, ".b"}, ex_b, e.b);
        checkOutput({e.tag, ".aluc"}, {28'd0, ex_aluc}, {28'd0, e.aluc});
        checkOutput({e.tag, ".wreg"}, {31'd0, ex_wreg}, {31'd0, e.wreg});
        checkOutput({e.tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
        checkOutput({e.tag, ".fwd_a"}, {30'd0, ex_fwd_a}, {30'd0, e.fa});
        checkOutput({e.tag, ".fwd_b"}, {30'd0, ex_fwd_b}, {30'd0, e.fb});
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    exp_t zero;
    exp_t instrA;
    zero   = mkExp("bubble", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 2'd0, 2'd0);
    clrn   = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    setInstr(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 5'd0);
    setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 clrn = 1'b0;
    #1 checkAllZero("rst0");
    @(negedge clk);
    clrn = 1'b1;

    // Plain load, no hazards
    setInstr(1'b1, 32'h11, 32'h22, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'h3, 1'b1, 5'd4);
    applyStimulus(1'b0, 1'b0, mkExp("plain", 1'b1, 32'h11, 32'h22, 4'h3, 1'b1, 5'd4, 2'd0, 2'd0));

    // Both mem and wb match rs: mem wins
    setInstr(1'b1, 32'h1, 32'h55, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 4'h2, 1'b1, 5'd7);
    setFwd(1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h9999);
    applyStimulus(1'b0, 1'b0, mkExp("memwins", 1'b1, FWD ? 32'h1234 : 32'h1, 32'h55,
                                    4'h2, 1'b1, 5'd7, FWD ? 2'd1 : 2'd0, 2'd0));

    // wb-only match on both rs and rt
    setInstr(1'b1, 32'h10, 32'h20, 5'd8, 5'd8, 1'b0, 1'b0, 5'd0, 4'h1, 1'b1, 5'd9);
    setFwd(1'b1, 5'd9, 32'h1234, 1'b1, 5'd8, 32'hABCD);
    applyStimulus(1'b0, 1'b0, mkExp("wbonly", 1'b1, FWD ? 32'hABCD : 32'h10,
                                    FWD ? 32'hABCD : 32'h20, 4'h1, 1'b1, 5'd9,
                                    FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0));

    // Register 0 never forwards
    setInstr(1'b1, 32'h3, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'h4, 1'b1, 5'd1);
    setFwd(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h77);
    applyStimulus(1'b0, 1'b0, mkExp("reg0", 1'b1, 32'h3, 32'h0, 4'h4, 1'b1, 5'd1, 2'd0, 2'd0));

    // Shift: a = shamt, b still forwards
    setInstr(1'b1, 32'h99, 32'h44, 5'd3, 5'd3, 1'b0, 1'b1, 5'd7, 4'h8, 1'b1, 5'd2);
    setFwd(1'b1, 5'd3, 32'h5000, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, mkExp("shift", 1'b1, 32'h7, FWD ? 32'h5000 : 32'h44,
                                    4'h8, 1'b1, 5'd2, 2'd0, FWD ? 2'd1 : 2'd0));

    // Immediate b is not forwarded; mem write disabled so wb forwards a
    setInstr(1'b1, 32'h66, 32'hFF, 5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 4'h5, 1'b1, 5'd3);
    setFwd(1'b0, 5'd3, 32'h5000, 1'b1, 5'd3, 32'h3333);
    applyStimulus(1'b0, 1'b0, mkExp("bimm", 1'b1, FWD ? 32'h3333 : 32'h66, 32'hFF,
                                    4'h5, 1'b1, 5'd3, FWD ? 2'd2 : 2'd0, 2'd0));

    // Decode bubble loads all zeros
    setInstr(1'b0, 32'h1, 32'h2, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'h5, 1'b1, 5'd9);
    setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, zero);

    // Instruction A (no write), then three stalls with changing inputs
    instrA = mkExp("stallA", 1'b1, 32'hA1, 32'hA2, 4'h6, 1'b0, 5'd12, 2'd0, 2'd0);
    setInstr(1'b1, 32'hA1, 32'hA2, 5'd10, 5'd11, 1'b0, 1'b0, 5'd0, 4'h6, 1'b0, 5'd12);
    applyStimulus(1'b0, 1'b0, instrA);
    for (int i = 0; i < 3; i++) begin
      setInstr(1'b1, 32'hB1 + i, 32'hB2 + i, 5'd10, 5'd11, 1'b0, 1'b0, 5'd0, 4'h9, 1'b1, 5'd13);
      setFwd(1'b1, 5'd10, 32'hDEAD, 1'b1, 5'd11, 32'hBEEF);
      applyStimulus(1'b1, 1'b0, instrA);
    end
    applyStimulus(1'b1, 1'b1, zero);

    // Flush alone over a valid instruction
    setInstr(1'b1, 32'hC1, 32'hC2, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'h4, 1'b1, 5'd3);
    setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, mkExp("loadB", 1'b1, 32'hC1, 32'hC2, 4'h4, 1'b1, 5'd3, 2'd0, 2'd0));
    applyStimulus(1'b0, 1'b1, zero);

    // Asynchronous reset mid-run with a valid instruction held
    setInstr(1'b1, 32'h1C, 32'h2C, 5'd4, 5'd5, 1'b0, 1'b0, 5'd0, 4'h7, 1'b1, 5'd6);
    applyStimulus(1'b0, 1'b0, mkExp("loadC", 1'b1, 32'h1C, 32'h2C, 4'h7, 1'b1, 5'd6, 2'd0, 2'd0));
    clrn = 1'b0;
    #1 checkAllZero("rstmid");
    @(negedge clk);
    clrn = 1'b1;
    setInstr(1'b1, 32'h1D, 32'h2D, 5'd4, 5'd5, 1'b0, 1'b0, 5'd0, 4'h8, 1'b1, 5'd14);
    applyStimulus(1'b0, 1'b0, mkExp("afterRst", 1'b1, 32'h1D, 32'h2D, 4'h8, 1'b1, 5'd14, 2'd0, 2'd0));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
